// File: rtl/genbus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : genbus_master                                                |
// | Description : Single-outstanding command-to-genbus master. It captures a   |
// |               request, drives byte strobes until the slave drops ws, and   |
// |               returns a one-cycle response. The optional wait-state abort  |
// |               is enabled by defining GENBUS_MST_TIMEOUT_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module genbus_master #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_adr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] adr,
    output logic [15:0] mdata,
    output logic [1:0]  we,
    output logic [1:0]  re,
    input  logic [15:0] sdata,
    input  logic        ws
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_be;
    logic [15:0] w_rdata_masked;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("genbus_master: TIMEOUT must be within 1..255");
        end
    endgenerate

`ifdef GENBUS_MST_TIMEOUT_EN
    // The counter holds the number of ws=1 cycles already seen in this access.
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
`endif

    assign w_rdata_masked = {r_be[1] ? sdata[15:8] : 8'h00,
                             r_be[0] ? sdata[7:0]  : 8'h00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_be      <= 2'b00;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
            adr       <= 16'h0000;
            mdata     <= 16'h0000;
            we        <= 2'b00;
            re        <= 2'b00;
`ifdef GENBUS_MST_TIMEOUT_EN
            r_wait_cnt <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_write   <= req_write;
                        r_be      <= req_be;
                        if (req_be == 2'b00) begin
                            // Nothing to transfer: answer with an error without touching the bus.
                            r_state   <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 16'h0000;
                        end else begin
                            r_state <= S_ACCESS;
                            adr     <= req_adr;
                            mdata   <= req_write ? req_wdata : 16'h0000;
                            we      <= req_write ? req_be : 2'b00;
                            re      <= req_write ? 2'b00 : req_be;
`ifdef GENBUS_MST_TIMEOUT_EN
                            r_wait_cnt <= 8'd0;
`endif
                        end
                    end
                end

                S_ACCESS: begin
                    if (!ws) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_write ? 16'h0000 : w_rdata_masked;
                        adr       <= 16'h0000;
                        mdata     <= 16'h0000;
                        we        <= 2'b00;
                        re        <= 2'b00;
                    end
`ifdef GENBUS_MST_TIMEOUT_EN
                    else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 16'h0000;
                        adr       <= 16'h0000;
                        mdata     <= 16'h0000;
                        we        <= 2'b00;
                        re        <= 2'b00;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
`endif
                end

                S_RESP: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end

                default: begin
                    r_state   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                    adr       <= 16'h0000;
                    mdata     <= 16'h0000;
                    we        <= 2'b00;
                    re        <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_genbus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_genbus_master                                             |
// | Description : Directed table plus randomized transactions for              |
// |               genbus_master, checked against a transaction-level model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_genbus_master;

    localparam int TIMEOUT = 15;
`ifdef GENBUS_MST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_adr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] adr;
    logic [15:0] mdata;
    logic [1:0]  we;
    logic [1:0]  re;
    logic [15:0] sdata;
    logic        ws;

    int n_checks = 0;
    int n_fail   = 0;

    genbus_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .adr       (adr),
        .mdata     (mdata),
        .we        (we),
        .re        (re),
        .sdata     (sdata),
        .ws        (ws)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          write;
        logic [15:0] adr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] sdata;
        int          nwait;
        logic [15:0] exp_rdata;
        bit          exp_err;
        int          exp_strobes;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation straight from the bus rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.be == 2'b00) begin
            r.exp_strobes = 0;
            r.exp_err     = 1'b1;
            r.exp_rdata   = 16'h0000;
        end else if (TO_EN && v.nwait >= TIMEOUT) begin
            r.exp_strobes = TIMEOUT;
            r.exp_err     = 1'b1;
            r.exp_rdata   = 16'h0000;
        end else begin
            r.exp_strobes = v.nwait + 1;
            r.exp_err     = 1'b0;
            r.exp_rdata   = v.write ? 16'h0000 : (v.sdata & {{8{v.be[1]}}, {8{v.be[0]}}});
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int g = 0;
        int strobes = 0;
        int rsp_at = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, " ready_before"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = v.write;
        req_adr   = v.adr;
        req_wdata = v.wdata;
        req_be    = v.be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_adr   = 16'($urandom);
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom);
        req_write = 1'($urandom);
        for (int k = 1; k <= 300 && rsp_at == 0; k++) begin
            ws    = (k <= v.nwait);
            sdata = v.sdata;
            @(negedge clk);
            if (k == 1) check({tag, " ready_busy"}, req_ready, 0);
            if (we != 2'b00 || re != 2'b00) begin
                strobes++;
                check({tag, " adr"}, adr, v.adr);
                check({tag, " we"}, we, v.write ? v.be : 2'b00);
                check({tag, " re"}, re, v.write ? 2'b00 : v.be);
                check({tag, " mdata"}, mdata, v.write ? v.wdata : 16'h0000);
            end
            if (rsp_valid) begin
                rsp_at = k;
                check({tag, " rsp_err"}, rsp_err, v.exp_err);
                check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, " rsp_cycle"}, rsp_at, v.exp_strobes + 1);
        check({tag, " strobe_cycles"}, strobes, v.exp_strobes);
        @(posedge clk);
        #1;
        ws = 1'b0;
        @(negedge clk);
        check({tag, " rsp_pulse_end"}, rsp_valid, 0);
        check({tag, " ready_after"}, req_ready, 1);
        check({tag, " err_hold"}, rsp_err, v.exp_err);
        check({tag, " rdata_hold"}, rsp_rdata, v.exp_rdata);
    endtask

    vec_t tbl[8];

    initial begin
        // write, adr, wdata, be, sdata, nwait, exp_rdata, exp_err, exp_strobes
        tbl[0] = '{1'b1, 16'h0000, 16'h00A5, 2'b01, 16'h0000, 0, 16'h0000, 1'b0, 1};
        tbl[1] = '{1'b0, 16'h0001, 16'h0000, 2'b01, 16'hFF03, 0, 16'h0003, 1'b0, 1};
        tbl[2] = '{1'b0, 16'h1234, 16'h0000, 2'b11, 16'hBEEF, 3, 16'hBEEF, 1'b0, 4};
        tbl[3] = '{1'b1, 16'h00F0, 16'h5A5A, 2'b00, 16'h0000, 0, 16'h0000, 1'b1, 0};
        tbl[4] = '{1'b0, 16'hA000, 16'h0000, 2'b10, 16'h1234, 0, 16'h1200, 1'b0, 1};
        tbl[5] = '{1'b0, 16'h0042, 16'h0000, 2'b01, 16'h77C3, 14, 16'h00C3, 1'b0, 15};
`ifdef GENBUS_MST_TIMEOUT_EN
        tbl[6] = '{1'b0, 16'h0BAD, 16'h0000, 2'b11, 16'h5555, 40, 16'h0000, 1'b1, 15};
`else
        tbl[6] = '{1'b0, 16'h0BAD, 16'h0000, 2'b11, 16'h5555, 20, 16'h5555, 1'b0, 21};
`endif
        tbl[7] = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'hFFFF, 0, 16'h0000, 1'b1, 0};

        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_adr = 16'h0;
        req_wdata = 16'h0;
        req_be = 2'b00;
        sdata = 16'h0;
        ws = 1'b0;

        #3;
        check("reset req_ready", req_ready, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset strobes", {adr, mdata, we, re}, 0);
        check("reset rsp", {rsp_rdata, rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("release ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        check("release ready_high", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a stalled read.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_adr   = 16'hC0DE;
        req_be    = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ws = 1'b1;
        @(negedge clk);
        check("midrst re_before", re, 2'b11);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst strobes", {adr, mdata, we, re}, 0);
        check("midrst rsp_valid", rsp_valid, 0);
        check("midrst ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst no_rsp", rsp_valid, 0);
        end
        ws = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        check("midrst ready_high", req_ready, 1);
        check("midrst no_rsp_after", rsp_valid, 0);

        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v.write = 1'($urandom);
            v.adr   = 16'($urandom);
            v.wdata = 16'($urandom);
            v.be    = 2'($urandom);
            v.sdata = 16'($urandom);
            if ($urandom_range(0, 7) == 0) v.nwait = TIMEOUT - 1 + $urandom_range(0, 4);
            else v.nwait = $urandom_range(0, 4);
            v.exp_rdata = 16'h0;
            v.exp_err = 1'b0;
            v.exp_strobes = 0;
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/genbus_master.md
GENBUS_MASTER -- requirements
Module: genbus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of consecutive strobe cycles with ws=1 before an access is aborted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port req_valid, input, 1, the requester presents a command.
REQ-005 SHALL have port req_ready, output, 1, the block accepts a command this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port req_adr, input, 16, the bus address.
REQ-008 SHALL have port req_wdata, input, 16, the write data.
REQ-009 SHALL have port req_be, input, 2, the byte enables (bit0 = [7:0], bit1 = [15:8]).
REQ-010 SHALL have port rsp_valid, output, 1, a one-cycle completion pulse (no backpressure).
REQ-011 SHALL have port rsp_rdata, output, 16, the read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err, output, 1, an error flag, valid with rsp_valid.
REQ-013 SHALL have genbus master-side ports: adr out 16, mdata out 16, we out 2, re out 2, sdata in 16, ws in 1 (1 = slave inserts a wait state).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; req_valid & req_ready captures adr, wdata, be and write into internal registers and moves to ACCESS next cycle.
REQ-016 SHALL, if the captured be==2'b00, skip ACCESS, drive no bus strobes, and go directly to RESP with rsp_err=1 and rsp_rdata=0.
REQ-017 SHALL, in ACCESS, drive adr=captured adr; for writes we=be, re=0, mdata=wdata; for reads re=be, we=0, mdata=0.
REQ-018 SHALL drive adr, mdata, we and re to 0 in IDLE and RESP.
REQ-019 SHALL, when ws=0 in an ACCESS cycle, complete the access: register rsp_rdata = sdata with non-enabled bytes zeroed (reads) or 0 (writes), set rsp_err=0, and go to RESP.
REQ-020 SHALL, while ws=1, hold all strobes and data unchanged in ACCESS and increment an 8-bit wait counter that is cleared on entry to ACCESS.
REQ-021 SHALL, when ws=1 in the TIMEOUT-th consecutive ACCESS cycle (timeout enabled), abort: go to RESP with rsp_err=1, rsp_rdata=0; strobes are 0 from the next cycle.
REQ-022 SHALL assert rsp_valid for exactly the one RESP cycle, then return to IDLE; rsp_rdata and rsp_err hold their last values otherwise.
REQ-023 SHALL meet zero-wait latency: command accepted in cycle N, strobes in N+1, rsp_valid in N+2, req_ready again in N+3.
REQ-024 SHALL complete an access normally if ws falls in the last allowed cycle (cycle TIMEOUT of ACCESS).

Reset
REQ-025 SHALL, on rst=0 at any time including mid-access, immediately force IDLE, clear counter and captured registers, drive adr/mdata/we/re/rsp_valid/rsp_rdata/rsp_err=0 and req_ready=0 during reset; no response is issued for the aborted access.
REQ-026 SHALL assert req_ready=1 on the first clock edge after rst deasserts.

Configuration
REQ-027 SHALL, with GENBUS_MST_TIMEOUT_EN defined, implement the wait counter and abort behaviour of REQ-020/021.
REQ-028 SHALL, without GENBUS_MST_TIMEOUT_EN, omit the counter, wait in ACCESS indefinitely while ws=1, and set rsp_err only for be==2'b00.

Verification
REQ-029 SHALL cover a zero-wait write: req adr=0x0000, wdata=0x00A5, be=01, write=1, ws=0 -> we=01, mdata=0x00A5 for one cycle; rsp_valid two cycles after acceptance; rsp_err=0.
REQ-030 SHALL cover a read with masking: adr=0x0001, be=01, sdata=0xFF03, ws=0 -> re=01; rsp_rdata=0x0003, rsp_err=0.
REQ-031 SHALL cover wait states: read with ws=1 for 3 cycles then 0 -> strobes held 4 cycles; rsp_valid in the cycle after ws=0; rsp_err=0.
REQ-032 SHALL cover timeout (macro on, TIMEOUT=15): ws held 1 -> strobes high exactly 15 cycles; rsp_valid with rsp_err=1, rsp_rdata=0; next request accepted normally.
REQ-033 SHALL cover zero byte enables: req with be=00 -> no we/re activity; rsp_valid one cycle after acceptance with rsp_err=1.
REQ-034 SHALL cover reset mid-access: rst=0 during ACCESS with ws=1 -> strobes 0 asynchronously, no rsp_valid; req_ready=1 one edge after release.
